// File: rtl/ad574_seq.sv
`default_nettype none
// ============================================================================
// Module   : ad574_seq
// Purpose  : Periodic conversion sequencer for an AD574-style 12-bit ADC.
//            A free-running tick (IN_CLK_FREQ/SAMPLE_RATE) launches a start
//            strobe. The sequencer then waits for STS to fall and reads the
//            result over a 12-bit bus, or over an 8-bit bus as two bytes.
//            The result is presented on a valid/ready handshake.
// Ports    : clk, rst (async, active-high)
//            enable_i      - run periodic conversions
//            short_cycle_i - 8-bit conversion, sampled at each start strobe
//            data_o/data_valid_o/data_ready_i - result handshake (MSB aligned)
//            overrun_o     - sticky, an unaccepted result was overwritten
//            timeout_o     - one-cycle pulse, STS never fell
//            busy_o        - sequencer is inside a conversion
//            ao_o, s12_8n_o, ce_o, rcn_o - ADC control pins
//            sts_i, db_i   - ADC status and data bus
// Options  : `define AD574_SEQ_AVG_EN to deliver the mean of every four
//            successful conversions instead of each conversion.
// Revision : 1.0 - initial release
// ============================================================================
module ad574_seq #(
  parameter int IN_CLK_FREQ     = 100_000_000,
  parameter int SAMPLE_RATE     = 100_000,
  parameter int BUS_WIDTH       = 12,
  parameter int T_PULSE_CYC     = 4,
  parameter int STS_TIMEOUT_CYC = 4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 short_cycle_i,
  output logic [11:0]          data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 overrun_o,
  output logic                 timeout_o,
  output logic                 busy_o,
  output logic                 ao_o,
  output logic                 s12_8n_o,
  output logic                 ce_o,
  output logic                 rcn_o,
  input  logic                 sts_i,
  input  logic [BUS_WIDTH-1:0] db_i
);

  localparam int c_div   = IN_CLK_FREQ / SAMPLE_RATE;
  localparam int c_div_w = $clog2(c_div);
  localparam int c_ph_w  = $clog2(T_PULSE_CYC + 1);
  localparam int c_tmo_w = $clog2(STS_TIMEOUT_CYC + 1);

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
  localparam logic [c_ph_w-1:0]  c_ph_cap   = c_ph_w'(T_PULSE_CYC - 1);
  localparam logic [c_ph_w-1:0]  c_ph_end   = c_ph_w'(T_PULSE_CYC);
  localparam logic [c_tmo_w-1:0] c_tmo_max  = c_tmo_w'(STS_TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_START     = 3'd2,
    S_CONV      = 3'd3,
    S_READ_HI   = 3'd4,
    S_READ_LO   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [c_ph_w-1:0]    ph_q, ph_d;
  logic [c_tmo_w-1:0]   tmo_q, tmo_d;
  logic                 seen_q, seen_d;
  logic                 sc_q, sc_d;
  logic                 timeout_q, timeout_d;

  logic [c_div_w-1:0]   cnt_q;
  logic                 tick_q;
  logic                 sts_meta_q, sts_sync_q;

  logic [BUS_WIDTH-1:0] hi_q;
  logic [11:0]          data_q;
  logic                 valid_q;
  logic                 overrun_q;

  logic                 w_cap_hi;
  logic                 w_cap_lo;
  logic                 w_done;
  logic                 w_two_reads;
  logic [11:0]          w_result;
  logic                 w_load;
  logic [11:0]          w_load_data;

  // --------------------------------------------------------------------------
  // Sample-rate tick: count wraps every c_div cycles, tick_q marks count == 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (!enable_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= (cnt_q == c_div_last) ? '0 : cnt_q + 1'b1;
      tick_q <= (cnt_q == c_div_last);
    end
  end

  // STS comes from the ADC clock domain; two-flop synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sts_meta_q <= 1'b0;
      sts_sync_q <= 1'b0;
    end else begin
      sts_meta_q <= sts_i;
      sts_sync_q <= sts_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      tmo_q     <= '0;
      seen_q    <= 1'b0;
      sc_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      tmo_q     <= tmo_d;
      seen_q    <= seen_d;
      sc_q      <= sc_d;
      timeout_q <= timeout_d;
    end
  end

  // Second byte read is only needed for a full conversion on the 8-bit bus.
  assign w_two_reads = (BUS_WIDTH == 8) && !sc_q;

  // --------------------------------------------------------------------------
  // Next state and pin decode. Read states last T_PULSE_CYC + 1 cycles so
  // CE drops for one cycle before the following strobe.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    tmo_d     = tmo_q;
    seen_d    = seen_q;
    sc_d      = sc_q;
    timeout_d = 1'b0;
    ce_o      = 1'b0;
    rcn_o     = 1'b1;
    ao_o      = 1'b0;
    w_cap_hi  = 1'b0;
    w_cap_lo  = 1'b0;
    w_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_WAIT_TICK;
      end

      S_WAIT_TICK: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (tick_q) begin
          state_d = S_START;
          ph_d    = '0;
          sc_d    = short_cycle_i;
        end
      end

      S_START: begin
        ce_o  = 1'b1;
        rcn_o = 1'b0;
        ao_o  = sc_q;
        if (ph_q == c_ph_cap) begin
          state_d = S_CONV;
          ph_d    = '0;
          tmo_d   = '0;
          seen_d  = 1'b0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      S_CONV: begin
        // End of conversion is a falling STS only after it was seen high,
        // so a stale low from before the start strobe is not mistaken for it.
        if (seen_q && !sts_sync_q) begin
          state_d = S_READ_HI;
          ph_d    = '0;
        end else if (tmo_q >= c_tmo_max) begin
          state_d   = S_WAIT_TICK;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (sts_sync_q) seen_d = 1'b1;
        end
      end

      S_READ_HI: begin
        ce_o     = (ph_q < c_ph_end);
        w_cap_hi = (ph_q == c_ph_cap);
        if (ph_q == c_ph_end) begin
          state_d = w_two_reads ? S_READ_LO : S_DONE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      S_READ_LO: begin
        ce_o     = (ph_q < c_ph_end);
        ao_o     = 1'b1;
        w_cap_lo = (ph_q == c_ph_cap);
        if (ph_q == c_ph_end) begin
          state_d = S_DONE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      S_DONE: begin
        w_done  = 1'b1;
        state_d = enable_i ? S_WAIT_TICK : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bus-width specific capture and result assembly
  // --------------------------------------------------------------------------
  generate
    if (BUS_WIDTH == 8) begin : g_bus8
      logic [3:0] lo_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lo_q <= '0;
        end else if (w_cap_lo) begin
          lo_q <= db_i[7:4];
        end
      end

      assign s12_8n_o = 1'b0;
      assign w_result = {hi_q[7:0], (sc_q ? 4'h0 : lo_q)};
    end else begin : g_bus12
      logic w_unused_cap_lo;
      assign w_unused_cap_lo = w_cap_lo;

      assign s12_8n_o = 1'b1;
      assign w_result = {hi_q[11:4], (sc_q ? 4'h0 : hi_q[3:0])};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Result selection: direct, or mean of four conversions
  // --------------------------------------------------------------------------
`ifdef AD574_SEQ_AVG_EN
  logic [13:0] acc_q;
  logic [1:0]  avg_cnt_q;
  logic [13:0] w_sum;

  assign w_sum       = acc_q + {2'b00, w_result};
  assign w_load      = w_done && (avg_cnt_q == 2'd3);
  assign w_load_data = w_sum[13:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else if (w_done) begin
      if (avg_cnt_q == 2'd3) begin
        acc_q     <= '0;
        avg_cnt_q <= '0;
      end else begin
        acc_q     <= w_sum;
        avg_cnt_q <= avg_cnt_q + 2'd1;
      end
    end
  end
`else
  assign w_load      = w_done;
  assign w_load_data = w_result;
`endif

  // --------------------------------------------------------------------------
  // Output register and handshake. A load wins over an accept in the same
  // cycle, so valid stays high; overrun only when the old value was dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (w_cap_hi) hi_q <= db_i;
      if (w_load) begin
        data_q  <= w_load_data;
        valid_q <= 1'b1;
        if (valid_q && !data_ready_i) overrun_q <= 1'b1;
      end else if (valid_q && data_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_WAIT_TICK);

endmodule
`default_nettype wire
